// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  localparam int BYTE_LANES = 8;
  localparam int OFFSET_W   = 3;

  // Lane-enable mask of an access of the given size, anchored at lane 0.
  function automatic logic [BYTE_LANES-1:0] size_mask(input size_e size);
    logic [BYTE_LANES-1:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// lsu_lane_align: combinational byte-lane extract/extend for loads and
// byte-lane merge for read-modify-write stores on a 64-bit memory word.
// Lanes shifted past lane 7 fall off: loads see zeros there, stores drop them.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0]         mem_word,
  input  logic [OFFSET_W-1:0] offset,
  input  size_e               size,
  input  logic                is_unsigned,
  input  logic [63:0]         wdata,
  output logic [63:0]         load_data,
  output logic [63:0]         merge_data
);

  logic [5:0]            shamt_s;
  logic [63:0]           shifted_s;
  logic [63:0]           wshift_s;
  logic [63:0]           bmask_s;
  logic [BYTE_LANES-1:0] lmask_s;

  assign shamt_s = {offset, 3'b000};

  // Load path: move the addressed lane to bit 0, then sign/zero extend by size
  always_comb begin
    shifted_s = mem_word >> shamt_s;
    load_data = 64'd0;
    case (size)
      SZ_B:    load_data = {{56{~is_unsigned & shifted_s[7]}},  shifted_s[7:0]};
      SZ_H:    load_data = {{48{~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
      SZ_W:    load_data = {{32{~is_unsigned & shifted_s[31]}}, shifted_s[31:0]};
      SZ_D:    load_data = shifted_s;
      default: load_data = 64'd0;
    endcase
  end

  // Store path: place store data at the offset and overwrite only enabled lanes
  always_comb begin
    lmask_s = size_mask(size) << offset;
    bmask_s = 64'd0;
    for (int i = 0; i < BYTE_LANES; i++) begin
      bmask_s[i*8 +: 8] = {8{lmask_s[i]}};
    end
    wshift_s   = wdata << shamt_s;
    merge_data = (mem_word & ~bmask_s) | (wshift_s & bmask_s);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store initiator for DataMemory
// (write on posedge, registered read on negedge). Sub-doubleword stores are
// read-modify-write. Build option LSU_ALIGN_CHECK_EN: when defined, misaligned
// accesses return resp_error; when undefined, only out-of-range is an error.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                write_q, write_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [ADDR_W-1:0]   idx_s;
  logic                oor_s;
  logic                misalign_s;
  logic [DATA_W-1:0]   load_s;
  logic [DATA_W-1:0]   merge_s;

  assign idx_s = req_addr >> 3;
  assign oor_s = (idx_s >= ADDR_W'(MEM_DEPTH));

`ifdef LSU_ALIGN_CHECK_EN
  // Offset within the doubleword must be a multiple of the access size
  always_comb begin
    case (size_e'(req_size))
      SZ_B:    misalign_s = 1'b0;
      SZ_H:    misalign_s = req_addr[0];
      SZ_W:    misalign_s = |req_addr[1:0];
      SZ_D:    misalign_s = |req_addr[2:0];
      default: misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .mem_word    (mem_rdata),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_s),
    .merge_data  (merge_s)
  );

  // Next-state and next-output logic; every output is registered from here
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_error_d  = resp_error_q;
    mem_address_d = mem_address_q;
    mem_write_d   = mem_write_q;
    mem_read_d    = mem_read_q;
    mem_wdata_d   = mem_wdata_q;
    write_d       = write_q;
    size_d        = size_q;
    uns_d         = uns_q;
    offset_d      = offset_q;
    wdata_d       = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d   = 1'b0;
          write_d       = req_write;
          size_d        = size_e'(req_size);
          uns_d         = req_unsigned;
          offset_d      = req_addr[OFFSET_W-1:0];
          wdata_d       = req_wdata;
          mem_address_d = idx_s;
          if (oor_s || misalign_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else if (req_write && (req_size == 2'd3)) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = READ;
            mem_read_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        mem_read_d = 1'b0;
        if (write_q) begin
          mem_wdata_d = merge_s;
          mem_write_d = 1'b1;
          state_d     = WRITE;
        end else begin
          resp_rdata_d = load_s;
          resp_error_d = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      WRITE: begin
        mem_write_d  = 1'b0;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_error_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops any in-flight strobe at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
      mem_address_q <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_wdata_q   <= '0;
      write_q       <= 1'b0;
      size_q        <= SZ_B;
      uns_q         <= 1'b0;
      offset_q      <= 3'd0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
      mem_address_q <= mem_address_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_wdata_q   <= mem_wdata_d;
      write_q       <= write_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      offset_q      <= offset_d;
      wdata_q       <= wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_error  = resp_error_q;
  assign mem_address = mem_address_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
